// File: rtl/decode_stage.sv
// decode_stage
//   Instruction-decode pipeline stage sitting between fetch and execute.
//   Reads the register file (with write-back bypass), extends the immediate,
//   detects load-use hazards and holds the decoded instruction in a
//   registered ID/EX slot with a valid/ready handshake.
//
// Parameters
//   XLEN     datapath width; immediate is extended to XLEN
//   NREGS    register count (power of two, 2..32); low log2(NREGS) bits of
//            each 5-bit register field index the file
//   ZERO_REG 1 = r0 reads 0 and ignores writes
//
// Ports
//   clk, rst_b              clock, synchronous active-high reset
//   in_valid/in_ready       fetch handshake for inst / pc4_in
//   wb_we/wb_num/wb_data    write-back port (also drives bypass + hold refresh)
//   ex_mem_read/ex_rt_num   load currently in EX (load-use hazard source)
//   flush, halted           squash the stage / freeze the stage
//   out_valid/out_ready     EX handshake for the ID/EX register
//   out_*                   decoded fields, operand data, immediate, PC+4
//   stall_cycles            load-use stall counter
//
// Build option
//   DECODE_PERF_EN  when defined, stall_cycles counts hazard cycles
//                   (saturating); otherwise it is tied to 0.

module decode_stage #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc4_in,
  input  logic            wb_we,
  input  logic [4:0]      wb_num,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rt_num,
  input  logic            flush,
  input  logic            halted,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs_data,
  output logic [XLEN-1:0] out_rt_data,
  output logic [4:0]      out_rs_num,
  output logic [4:0]      out_rt_num,
  output logic [4:0]      out_rd_num,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_opcode,
  output logic [5:0]      out_func,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc4,
  output logic [31:0]     stall_cycles
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef struct packed {
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [4:0]      rs_num;
    logic [4:0]      rt_num;
    logic [4:0]      rd_num;
    logic [4:0]      shamt;
    logic [5:0]      opcode;
    logic [5:0]      func;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc4;
  } idex_t;

  // ---------------------------------------------------------------------------
  // Field decode
  // ---------------------------------------------------------------------------
  logic [5:0]    opcode;
  logic [4:0]    rs_num, rt_num;
  logic [IW-1:0] rs_idx, rt_idx, wb_idx;

  assign opcode = inst[31:26];
  assign rs_num = inst[25:21];
  assign rt_num = inst[20:16];
  assign rs_idx = rs_num[IW-1:0];
  assign rt_idx = rt_num[IW-1:0];
  assign wb_idx = wb_num[IW-1:0];

  logic zext, uses_rt;
  assign zext    = opcode inside {6'h0C, 6'h0D, 6'h0E};
  assign uses_rt = opcode inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h2B};

  logic [XLEN-1:0] imm;
  assign imm = zext ? {{(XLEN-16){1'b0}},     inst[15:0]}
                    : {{(XLEN-16){inst[15]}}, inst[15:0]};

  // ---------------------------------------------------------------------------
  // Register file with write-first bypass
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf [NREGS];
  logic            wb_fire, wb_wr;

  assign wb_fire = wb_we && !halted;
  // r0 writes are discarded entirely, so they must not bypass or refresh either
  assign wb_wr   = wb_fire && !((ZERO_REG != 0) && (wb_idx == '0));

  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_wr) begin
      rf[wb_idx] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs_data, rt_data;

  always_comb begin
    rs_data = rf[rs_idx];
    if (wb_wr && (wb_idx == rs_idx)) rs_data = wb_data;
    if ((ZERO_REG != 0) && (rs_idx == '0)) rs_data = '0;
  end

  always_comb begin
    rt_data = rf[rt_idx];
    if (wb_wr && (wb_idx == rt_idx)) rt_data = wb_data;
    if ((ZERO_REG != 0) && (rt_idx == '0)) rt_data = '0;
  end

  // ---------------------------------------------------------------------------
  // Hazard and handshake
  // ---------------------------------------------------------------------------
  logic hazard, load;
  idex_t idex_q, idex_d;
  logic  vld_q;

  // Full 5-bit compares: the EX destination field is architectural, not an index
  assign hazard = in_valid && ex_mem_read && (ex_rt_num != 5'd0) &&
                  ((ex_rt_num == rs_num) || (uses_rt && (ex_rt_num == rt_num)));
  assign load     = !vld_q || out_ready;
  assign in_ready = flush || (load && !hazard && !halted);

  always_comb begin
    idex_d         = '0;
    idex_d.rs_data = rs_data;
    idex_d.rt_data = rt_data;
    idex_d.rs_num  = rs_num;
    idex_d.rt_num  = rt_num;
    idex_d.rd_num  = inst[15:11];
    idex_d.shamt   = inst[10:6];
    idex_d.opcode  = opcode;
    idex_d.func    = inst[5:0];
    idex_d.imm     = imm;
    idex_d.pc4     = pc4_in;
  end

  // Write-back landing on a held operand keeps the ID/EX copy coherent
  logic hit_rs, hit_rt;
  assign hit_rs = wb_wr && (idex_q.rs_num[IW-1:0] == wb_idx);
  assign hit_rt = wb_wr && (idex_q.rt_num[IW-1:0] == wb_idx);

  // ---------------------------------------------------------------------------
  // ID/EX register: reset > flush > halted > load > hold(+refresh)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_b) begin
      vld_q  <= 1'b0;
      idex_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (!halted) begin
      if (load) begin
        // fields are captured even on a bubble; only the valid bit drops
        vld_q  <= in_valid && !hazard;
        idex_q <= idex_d;
      end else if (vld_q) begin
        if (hit_rs) idex_q.rs_data <= wb_data;
        if (hit_rt) idex_q.rt_data <= wb_data;
      end
    end
  end

  assign out_valid   = vld_q;
  assign out_rs_data = idex_q.rs_data;
  assign out_rt_data = idex_q.rt_data;
  assign out_rs_num  = idex_q.rs_num;
  assign out_rt_num  = idex_q.rt_num;
  assign out_rd_num  = idex_q.rd_num;
  assign out_shamt   = idex_q.shamt;
  assign out_opcode  = idex_q.opcode;
  assign out_func    = idex_q.func;
  assign out_imm     = idex_q.imm;
  assign out_pc4     = idex_q.pc4;

  // ---------------------------------------------------------------------------
  // Load-use stall counter
  // ---------------------------------------------------------------------------
`ifdef DECODE_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      stall_q <= '0;
    end else if (!halted && hazard && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (default parameters). A scoreboard
// queues each accepted instruction; when EX consumes the ID/EX register the
// fields are compared and operand data is checked against a reference
// register-file model as it stands at consumption time.

module tb_decode_stage;

`ifdef DECODE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_b, in_valid, in_ready;
  logic [31:0] inst, pc4_in;
  logic        wb_we;
  logic [4:0]  wb_num;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rt_num;
  logic        flush, halted, out_valid, out_ready;
  logic [31:0] out_rs_data, out_rt_data, out_imm, out_pc4, stall_cycles;
  logic [4:0]  out_rs_num, out_rt_num, out_rd_num, out_shamt;
  logic [5:0]  out_opcode, out_func;

  int tests = 0;
  int fails = 0;

  decode_stage dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc4_in(pc4_in), .wb_we(wb_we), .wb_num(wb_num),
    .wb_data(wb_data), .ex_mem_read(ex_mem_read), .ex_rt_num(ex_rt_num),
    .flush(flush), .halted(halted), .out_valid(out_valid),
    .out_ready(out_ready), .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data), .out_rs_num(out_rs_num),
    .out_rt_num(out_rt_num), .out_rd_num(out_rd_num), .out_shamt(out_shamt),
    .out_opcode(out_opcode), .out_func(out_func), .out_imm(out_imm),
    .out_pc4(out_pc4), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mrf [32];

  function automatic logic [31:0] mread(input logic [4:0] n);
    return (n == 5'd0) ? 32'd0 : mrf[n];
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    if (i[31:26] == 6'h0C || i[31:26] == 6'h0D || i[31:26] == 6'h0E)
      return {16'h0000, i[15:0]};
    return {{16{i[15]}}, i[15:0]};
  endfunction

  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 32; i++) mrf[i] <= 32'd0;
      sbq.delete();
    end else begin
      if (wb_we && !halted && wb_num != 5'd0) mrf[wb_num] <= wb_data;
      if (flush) sbq.delete();
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b && !flush && !halted) begin
      if (out_valid && out_ready) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected_output got opcode=%0h want no output", out_opcode);
        end else begin
          e = sbq.pop_front();
          tests++;
          if ({out_opcode, out_rs_num, out_rt_num, out_rd_num, out_shamt, out_func} !== e.inst) begin
            fails++;
            $display("FAIL sb_fields got %08h want %08h",
                     {out_opcode, out_rs_num, out_rt_num, out_rd_num, out_shamt, out_func}, e.inst);
          end
          tests++;
          if (out_rs_data !== mread(e.inst[25:21]) || out_rt_data !== mread(e.inst[20:16])) begin
            fails++;
            $display("FAIL sb_data got rs=%08h rt=%08h want rs=%08h rt=%08h",
                     out_rs_data, out_rt_data, mread(e.inst[25:21]), mread(e.inst[20:16]));
          end
          tests++;
          if (out_imm !== exp_imm(e.inst) || out_pc4 !== e.pc4) begin
            fails++;
            $display("FAIL sb_imm_pc4 got imm=%08h pc4=%08h want imm=%08h pc4=%08h",
                     out_imm, out_pc4, exp_imm(e.inst), e.pc4);
          end
        end
      end
      if (in_valid && in_ready) sbq.push_back('{inst: inst, pc4: pc4_in});
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inst(input logic [31:0] i);
    inst     = i;
    pc_ctr   = pc_ctr + 32'd4;
    pc4_in   = pc_ctr;
    in_valid = 1'b1;
  endtask

  task automatic do_wb(input logic [4:0] n, input logic [31:0] d);
    wb_we = 1'b1; wb_num = n; wb_data = d;
  endtask

  localparam logic [31:0] ADD_R3_R5_R0 = 32'h00A0_1820;
  localparam logic [31:0] ADD_R4_R7_R0 = 32'h00E0_2020;
  localparam logic [31:0] ADD_R1_R5_R0 = 32'h00A0_0820;
  localparam logic [31:0] ADD_R8_R6_R0 = 32'h00C0_4020;
  localparam logic [31:0] ADD_R9_R5_R0 = 32'h00A0_4820;
  localparam logic [31:0] ADD_R1_R0_R0 = 32'h0000_0820;
  localparam logic [31:0] ORI_R2       = 32'h3402_8001;
  localparam logic [31:0] ADDI_R2      = 32'h2002_8001;
  localparam logic [31:0] SW_R5_R1     = 32'hAC25_0000;
  localparam logic [31:0] LW_R5_R1     = 32'h8C25_0004;

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_b = 1'b1; in_valid = 1'b0; inst = '0; pc4_in = '0; wb_we = 1'b0;
    wb_num = '0; wb_data = '0; ex_mem_read = 1'b0; ex_rt_num = '0;
    flush = 1'b0; halted = 1'b0; out_ready = 1'b0;
    repeat (2) tick;
    tests++;
    if (out_valid !== 1'b0 || out_rs_data !== 0 || out_imm !== 0 || out_pc4 !== 0) begin
      fails++;
      $display("FAIL reset_outputs got v=%0b rs=%08h imm=%08h pc4=%08h want all 0",
               out_valid, out_rs_data, out_imm, out_pc4);
    end
    tests++;
    if (stall_cycles !== 32'd0) begin
      fails++; $display("FAIL reset_stall got %0d want 0", stall_cycles);
    end
    rst_b = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
  endtask

  task automatic test_read_bypass;
    do_wb(5'd5, 32'h1234);
    tick;
    wb_we = 1'b0;
    drive_inst(ADD_R3_R5_R0);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL add_accept got rdy=%0b v=%0b want rdy=1 v=0", in_ready, out_valid);
    end
    tick;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_rs_data !== 32'h1234 || out_rt_data !== 0 || out_rd_num !== 5'd3) begin
      fails++;
      $display("FAIL add_capture got v=%0b rs=%08h rt=%08h rd=%0d want v=1 rs=00001234 rt=0 rd=3",
               out_valid, out_rs_data, out_rt_data, out_rd_num);
    end
    out_ready = 1'b1;
    tick;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL add_drain got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_imm_back_to_back;
    drive_inst(ORI_R2);
    tick;
    drive_inst(ADDI_R2);
    tests++;
    if (out_valid !== 1'b1 || out_imm !== 32'h0000_8001) begin
      fails++; $display("FAIL ori_imm got v=%0b imm=%08h want v=1 imm=00008001", out_valid, out_imm);
    end
    tick;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFF_8001) begin
      fails++; $display("FAIL addi_imm got v=%0b imm=%08h want v=1 imm=ffff8001", out_valid, out_imm);
    end
    tick;
  endtask

  task automatic test_hazard;
    ex_mem_read = 1'b1; ex_rt_num = 5'd5;
    drive_inst(SW_R5_R1);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL hazard_stall got in_ready=%0b want 0", in_ready);
    end
    tick;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL hazard_bubble got v=%0b want 0", out_valid);
    end
    ex_mem_read = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL hazard_release got in_ready=%0b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_rt_data !== 32'h1234 || stall_cycles !== (PERF ? 32'd1 : 32'd0)) begin
      fails++;
      $display("FAIL hazard_accept got v=%0b rt=%08h stall=%0d want v=1 rt=00001234 stall=%0d",
               out_valid, out_rt_data, stall_cycles, PERF ? 1 : 0);
    end
    // lw does not read rt, so a matching rt must not stall
    ex_mem_read = 1'b1; ex_rt_num = 5'd5;
    drive_inst(LW_R5_R1);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL lw_no_hazard got in_ready=%0b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0; ex_mem_read = 1'b0;
    tick;
  endtask

  task automatic test_hold_refresh;
    out_ready = 1'b0;
    drive_inst(ADD_R4_R7_R0);
    tick;
    drive_inst(ADD_R1_R5_R0);
    #1;
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL hold_backpressure got v=%0b rdy=%0b want v=1 rdy=0", out_valid, in_ready);
    end
    do_wb(5'd7, 32'hBEEF);
    tick;
    wb_we = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_rs_data !== 32'hBEEF) begin
      fails++; $display("FAIL hold_refresh got v=%0b rs=%08h want v=1 rs=0000beef", out_valid, out_rs_data);
    end
    out_ready = 1'b1;
    tick;
    // write and read of the same register in one cycle captures the new value
    drive_inst(ADD_R8_R6_R0);
    do_wb(5'd6, 32'h5555);
    tick;
    in_valid = 1'b0; wb_we = 1'b0;
    tests++;
    if (out_rs_data !== 32'h5555 || out_rd_num !== 5'd8) begin
      fails++; $display("FAIL wb_same_cycle got rs=%08h rd=%0d want rs=00005555 rd=8", out_rs_data, out_rd_num);
    end
    tick;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive_inst(ADD_R3_R5_R0);
    tick;
    drive_inst(ADD_R9_R5_R0);
    flush = 1'b1; ex_mem_read = 1'b1; ex_rt_num = 5'd5;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_over_hazard got in_ready=%0b want 1", in_ready);
    end
    tick;
    flush = 1'b0; in_valid = 1'b0; ex_mem_read = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || stall_cycles !== (PERF ? 32'd2 : 32'd0)) begin
      fails++;
      $display("FAIL flush_squash got v=%0b stall=%0d want v=0 stall=%0d",
               out_valid, stall_cycles, PERF ? 2 : 0);
    end
    out_ready = 1'b1;
    do_wb(5'd0, 32'hFF);
    drive_inst(ADD_R1_R0_R0);
    tick;
    wb_we = 1'b0;
    drive_inst(ADD_R1_R0_R0);
    tests++;
    if (out_valid !== 1'b1 || out_rs_data !== 32'd0) begin
      fails++; $display("FAIL r0_same_cycle got v=%0b rs=%08h want v=1 rs=0", out_valid, out_rs_data);
    end
    tick;
    in_valid = 1'b0;
    tests++;
    if (out_rs_data !== 32'd0 || out_rt_data !== 32'd0) begin
      fails++; $display("FAIL r0_after_write got rs=%08h rt=%08h want 0", out_rs_data, out_rt_data);
    end
    tick;
  endtask

  task automatic test_halt;
    out_ready = 1'b0;
    drive_inst(ADD_R3_R5_R0);
    tick;
    halted = 1'b1; out_ready = 1'b1;
    drive_inst(ADD_R4_R7_R0);
    do_wb(5'd5, 32'h9999);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL halt_in_ready got %0b want 0", in_ready);
    end
    repeat (2) tick;
    tests++;
    if (out_valid !== 1'b1 || out_rs_data !== 32'h1234 || out_rd_num !== 5'd3) begin
      fails++;
      $display("FAIL halt_frozen got v=%0b rs=%08h rd=%0d want v=1 rs=00001234 rd=3",
               out_valid, out_rs_data, out_rd_num);
    end
    halted = 1'b0; wb_we = 1'b0; in_valid = 1'b0;
    tick;
    drive_inst(ADD_R3_R5_R0);
    tick;
    in_valid = 1'b0;
    tests++;
    if (out_rs_data !== 32'h1234) begin
      fails++; $display("FAIL halt_wb_ignored got rs=%08h want 00001234", out_rs_data);
    end
    tick;
  endtask

  task automatic test_reset_mid_hold;
    out_ready = 1'b0;
    drive_inst(ADD_R3_R5_R0);
    tick;
    in_valid = 1'b0;
    rst_b = 1'b1;
    tick;
    rst_b = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_rs_data !== 32'd0 || stall_cycles !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_hold got v=%0b rs=%08h stall=%0d want 0", out_valid, out_rs_data, stall_cycles);
    end
    drive_inst(ADD_R3_R5_R0);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL post_reset_ready got %0b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_rs_data !== 32'd0) begin
      fails++; $display("FAIL post_reset_accept got v=%0b rs=%08h want v=1 rs=0", out_valid, out_rs_data);
    end
    out_ready = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_read_bypass;
    test_imm_back_to_back;
    test_hazard;
    test_hold_refresh;
    test_flush;
    test_halt;
    test_reset_mid_hold;
    repeat (2) tick;
    tests++;
    if (sbq.size() != 0) begin
      fails++; $display("FAIL sb_pending got %0d entries want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
